mem_burst_ctrl: RTL and testbench

Upstream master for the single-port `memory` block (shared bidirectional data bus, `wr`/`rd` strobes).
- Accepts burst requests on a valid/ready handshake: start address, length, direction.
- Sequences one memory beat per cycle, with auto-increment addressing and tri-state bus control.
- Streams write data in and read data out, so the client never touches the `memory` bus timing.

---
 rtl/mem_ctrl_pkg.sv | 13 +
 rtl/mem_addr_gen.sv | 37 +++
 rtl/mem_burst_ctrl.sv | 95 +++++++++
 tb/tb_mem_burst_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the burst controller: FSM states and transfer direction.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

endpackage

// File: rtl/mem_addr_gen.sv
// Burst address register with modulo-2**AWIDTH increment and a beat down-counter.
module mem_addr_gen #(
  parameter int AWIDTH = 5,
  parameter int LWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [AWIDTH-1:0] load_addr,
  input  logic [LWIDTH-1:0] load_len,
  input  logic              advance,
  output logic [AWIDTH-1:0] addr,
  output logic              last_beat
);

  localparam logic [AWIDTH-1:0] ADDR_ONE = AWIDTH'(1);
  localparam logic [LWIDTH-1:0] CNT_ONE  = LWIDTH'(1);

  logic [LWIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      addr  <= load_addr;
      cnt_q <= load_len;
    end else if (advance) begin
      addr  <= addr + ADDR_ONE;
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

  // Counter holds beats-minus-one, so zero marks the beat being issued as the last.
  assign last_beat = (cnt_q == '0);

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst master for the single-port memory: one beat per cycle, registered strobes,
// tri-state write drive, read data captured the edge after each read strobe.
module mem_burst_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8,
  parameter int LWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [LWIDTH-1:0] req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DWIDTH-1:0] wdata,
  output logic              rdata_valid,
  output logic [DWIDTH-1:0] rdata,
  output logic              busy,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [AWIDTH-1:0] mem_addr,
  inout  wire  [DWIDTH-1:0] mem_data
);

  // Handshakes: a transfer happens at a rising edge where valid and ready are both 1.
  // Ready depends only on FSM state (and reset), never on valid.
  state_t            state_q;
  logic [AWIDTH-1:0] addr_q;
  logic              last_beat;
  logic [DWIDTH-1:0] wdata_q;
  logic              req_fire;
  logic              issue_wr;
  logic              issue_rd;

  assign req_ready   = (state_q == IDLE) && !rst;
  assign wdata_ready = (state_q == WRITE) && !rst;
  assign req_fire    = req_valid && req_ready;
  assign issue_wr    = (state_q == WRITE) && wdata_valid;
  assign issue_rd    = (state_q == READ);

  mem_addr_gen #(
    .AWIDTH (AWIDTH),
    .LWIDTH (LWIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (req_fire),
    .load_addr (req_addr),
    .load_len  (req_len),
    .advance   (issue_wr || issue_rd),
    .addr      (addr_q),
    .last_beat (last_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      wdata_q     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      mem_wr      <= issue_wr;
      mem_rd      <= issue_rd;
      rdata_valid <= mem_rd;
      // The memory drives the bus combinationally while mem_rd is high.
      if (mem_rd) rdata <= mem_data;
      if (issue_wr || issue_rd) mem_addr <= addr_q;
      if (issue_wr) wdata_q <= wdata;
      case (state_q)
        IDLE: begin
          if (req_fire) state_q <= (req_write == DIR_WRITE) ? WRITE : READ;
        end
        WRITE: begin
          if (issue_wr && last_beat) state_q <= IDLE;
        end
        READ: begin
          if (last_beat) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // mem_rd high also means a read capture is still owed at the next edge.
  assign busy     = (state_q != IDLE) || mem_wr || mem_rd;
  assign mem_data = mem_wr ? wdata_q : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl with a behavioural single-port memory on the shared bus.
module tb_mem_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [4:0] req_addr = '0;
  logic [4:0] req_len = '0;
  logic       wdata_valid = 1'b0;
  logic       wdata_ready;
  logic [7:0] wdata = '0;
  logic       rdata_valid;
  logic [7:0] rdata;
  logic       busy;
  logic       mem_wr;
  logic       mem_rd;
  logic [4:0] mem_addr;
  wire  [7:0] mem_bus;

  int checks = 0;
  int errors = 0;
  int wr_cycles = 0;
  bit mon_en = 1'b0;
  bit prev_rd = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] model[32];
  logic [7:0] stub[32];

  always #5 clk = ~clk;

  mem_burst_ctrl #(.AWIDTH(5), .DWIDTH(8), .LWIDTH(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .busy        (busy),
    .mem_wr      (mem_wr),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_data    (mem_bus)
  );

  // Single-port memory: combinational read drive, write commit on the clock edge.
  assign mem_bus = (mem_rd && !mem_wr) ? stub[mem_addr] : 8'bzzzzzzzz;

  always @(posedge clk) begin
    if (mem_wr) stub[mem_addr] <= mem_bus;
  end

  // Bus protocol monitor and read-data scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (mem_wr === 1'b1 && mem_rd === 1'b1) begin
        errors++;
        $display("FAIL strobe_excl: mem_wr=%b mem_rd=%b required not both 1", mem_wr, mem_rd);
      end
      if (mem_wr === 1'b1) begin
        wr_cycles++;
        checks++;
        if (prev_rd) begin
          errors++;
          $display("FAIL turnaround: mem_wr=1 directly after a mem_rd cycle, required an idle bus cycle");
        end
      end
      prev_rd = (mem_rd === 1'b1);
      if (rdata_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rdata_extra: rdata_valid=1 rdata=%02h with no read outstanding", rdata);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rdata !== e) begin
            errors++;
            $display("FAIL rdata: got %02h required %02h", rdata, e);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || wdata_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b wdata_ready=%b busy=%b required 0 0 0",
               req_ready, wdata_ready, busy);
    end
    checks++;
    if (mem_wr !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_mem: mem_wr=%b mem_rd=%b mem_addr=%0d required 0 0 0",
               mem_wr, mem_rd, mem_addr);
    end
    checks++;
    if (rdata_valid !== 1'b0 || rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata: rdata_valid=%b rdata=%02h required 0 00", rdata_valid, rdata);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || wdata_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: req_ready=%b wdata_ready=%b required 1 0", req_ready, wdata_ready);
    end
  endtask

  // Entered and left at a falling edge. data_mode: 0 = beat index, 1 = ~addr, 2 = random.
  task automatic write_burst(input logic [4:0] a, input logic [4:0] len, input int data_mode,
                             input int gap_at, input int gap_len);
    logic [4:0] ba;
    logic [7:0] d;
    int base;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    req_len   = len;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_req_ready: req_ready=%b required 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 5'($urandom_range(0, 31));
    base = wr_cycles;
    checks++;
    if (wdata_ready !== 1'b1 || mem_wr !== 1'b0 || mem_rd !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_accept: wdata_ready=%b mem_wr=%b mem_rd=%b busy=%b required 1 0 0 1",
               wdata_ready, mem_wr, mem_rd, busy);
    end
    for (int i = 0; i <= int'(len); i++) begin
      ba = a + 5'(i);
      case (data_mode)
        0:       d = 8'(i);
        1:       d = ~{3'b000, ba};
        default: d = 8'($urandom_range(0, 255));
      endcase
      if (i == gap_at) begin
        wdata_valid = 1'b0;
        wdata = 8'($urandom_range(0, 255));
        repeat (gap_len) begin
          @(posedge clk);
          @(negedge clk);
          checks++;
          if (mem_wr !== 1'b0 || wdata_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_bubble: mem_wr=%b wdata_ready=%b required 0 1", mem_wr, wdata_ready);
          end
        end
      end
      wdata_valid = 1'b1;
      wdata = d;
      model[ba] = d;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_wr !== 1'b1 || mem_addr !== ba || mem_bus !== d) begin
        errors++;
        $display("FAIL wr_beat%0d: mem_wr=%b addr=%0d data=%02h required 1 %0d %02h",
                 i, mem_wr, mem_addr, mem_bus, ba, d);
      end
    end
    wdata_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_wr !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || wdata_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: mem_wr=%b busy=%b req_ready=%b wdata_ready=%b required 0 0 1 0",
               mem_wr, busy, req_ready, wdata_ready);
    end
    checks++;
    if (wr_cycles - base != int'(len) + 1) begin
      errors++;
      $display("FAIL wr_count: %0d write strobes, required %0d", wr_cycles - base, int'(len) + 1);
    end
  endtask

  // Entered at a falling edge; with drain=0 it returns right after the last strobe issues.
  task automatic read_burst(input logic [4:0] a, input logic [4:0] len, input bit drain);
    logic [4:0] ba;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a;
    req_len   = len;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_req_ready: req_ready=%b required 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) exp_q.push_back(model[a + 5'(i)]);
    for (int i = 0; i <= int'(len); i++) begin
      ba = a + 5'(i);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== ba || rdata_valid !== (i > 0)) begin
        errors++;
        $display("FAIL rd_beat%0d: mem_rd=%b mem_wr=%b addr=%0d rdata_valid=%b required 1 0 %0d %b",
                 i, mem_rd, mem_wr, mem_addr, rdata_valid, ba, (i > 0));
      end
    end
    if (drain) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_rd !== 1'b0 || rdata_valid !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rd_last: mem_rd=%b rdata_valid=%b busy=%b required 0 1 0",
                 mem_rd, rdata_valid, busy);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rdata_valid !== 1'b0 || exp_q.size() != 0) begin
        errors++;
        $display("FAIL rd_drain: rdata_valid=%b outstanding=%0d required 0 0",
                 rdata_valid, exp_q.size());
      end
    end
  endtask

  task automatic test_write_wrap();
    write_burst(5'd31, 5'd3, 0, -1, 0);
  endtask

  task automatic test_read_wrap();
    read_burst(5'd31, 5'd3, 1'b1);
  endtask

  task automatic test_write_gap();
    write_burst(5'd10, 5'd3, 2, 2, 2);
    read_burst(5'd10, 5'd3, 1'b1);
  endtask

  task automatic test_full_burst();
    write_burst(5'd0, 5'd31, 1, -1, 0);
    read_burst(5'd0, 5'd31, 1'b1);
  endtask

  task automatic test_back_to_back();
    write_burst(5'd5, 5'd2, 2, -1, 0);
    read_burst(5'd5, 5'd2, 1'b0);
    write_burst(5'd20, 5'd1, 2, -1, 0);
    read_burst(5'd20, 5'd1, 1'b1);
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 5'd0;
    req_len   = 5'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    // Only beat 0 is captured before reset lands on beat 2's edge.
    exp_q.push_back(model[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 5'd1) begin
      errors++;
      $display("FAIL rstmid_pre: mem_rd=%b addr=%0d required 1 1", mem_rd, mem_addr);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || rdata_valid !== 1'b0 || busy !== 1'b0 ||
        req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid: mem_rd=%b mem_wr=%b rdata_valid=%b busy=%b req_ready=%b required 0 0 0 0 0",
               mem_rd, mem_wr, rdata_valid, busy, req_ready);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_q: outstanding=%0d required 0", exp_q.size());
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rdata_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_post: req_ready=%b rdata_valid=%b required 1 0", req_ready, rdata_valid);
    end
    read_burst(5'd3, 5'd0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      model[i] = 8'h00;
      stub[i]  = 8'h00;
    end
    test_reset();
    mon_en = 1'b1;
    test_write_wrap();
    test_read_wrap();
    test_write_gap();
    test_full_burst();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: outstanding=%0d required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
